spi_mstr_arb: RTL and testbench

// - Shares the single SPI_mstr16 between two command-level requesters: port 0 (inert_intf, inertial

---
 rtl/spi_arb_pkg.sv | 6 +
 rtl/spi_arb_port.sv | 46 ++++
 rtl/spi_mstr_arb.sv | 118 +++++++++++
 tb/tb_spi_mstr_arb.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types for the two-port SPI_mstr16 arbiter.
package spi_arb_pkg;
  localparam int NUM_PORTS = 2;
  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, HOLD = 2'd2} arb_state_t;
  typedef logic owner_t;
endpackage

// File: rtl/spi_arb_port.sv
// One requester slot: captures wrt/cmd into a pending command, flags overruns.
module spi_arb_port
  import spi_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt_i,
  input  logic [15:0] cmd_i,
  input  logic        clr_i,
  output logic        pend_o,
  output logic [15:0] pcmd_o,
  output logic        ovr_o
);
  logic        pend_q, pend_d, ovr_q, ovr_d;
  logic [15:0] pcmd_q, pcmd_d;

  always_comb begin
    pend_d = pend_q;
    pcmd_d = pcmd_q;
    ovr_d  = ovr_q;
    // A new request in the clearing cycle re-arms the slot, so clients may chain on done.
    if (wrt_i && (!pend_q || clr_i)) begin
      pend_d = 1'b1;
      pcmd_d = cmd_i;
    end else if (clr_i) begin
      pend_d = 1'b0;
    end
    if (wrt_i && pend_q && !clr_i) ovr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      pcmd_q <= '0;
      ovr_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      pcmd_q <= pcmd_d;
      ovr_q  <= ovr_d;
    end
  end

  assign pend_o = pend_q;
  assign pcmd_o = pcmd_q;
  assign ovr_o  = ovr_q;
endmodule

// File: rtl/spi_mstr_arb.sv
// Round-robin arbiter sharing one SPI_mstr16 between two command-level clients,
// with a per-port burst lock capped at LOCK_MAX transactions while the other port waits.
module spi_mstr_arb
  import spi_arb_pkg::*;
#(
  parameter int LOCK_MAX = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt0,
  input  logic [15:0] cmd0,
  input  logic        lock0,
  output logic        done0,
  output logic [15:0] rd_data0,
  input  logic        wrt1,
  input  logic [15:0] cmd1,
  input  logic        lock1,
  output logic        done1,
  output logic [15:0] rd_data1,
  output logic [1:0]  ovr,
  output logic [1:0]  gnt,
  output logic        wrt_m,
  output logic [15:0] cmd_m,
  input  logic        done_m,
  input  logic [15:0] rd_data_m
);
  localparam int CW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_MAX - 1);

  arb_state_t                       state_q, state_d;
  logic [NUM_PORTS-1:0]             gnt_q, gnt_d, pend, clr, wrt_v, lock_v, ovr_v;
  logic [NUM_PORTS-1:0][15:0]       cmd_v, pcmd;
  owner_t                           last_q, last_d, own, win, sel;
  logic [CW-1:0]                    cnt_q, cnt_d;

  assign wrt_v  = {wrt1, wrt0};
  assign cmd_v  = {cmd1, cmd0};
  assign lock_v = {lock1, lock0};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    spi_arb_port u_port (
      .clk    (clk),
      .rst_n  (rst_n),
      .wrt_i  (wrt_v[p]),
      .cmd_i  (cmd_v[p]),
      .clr_i  (clr[p]),
      .pend_o (pend[p]),
      .pcmd_o (pcmd[p]),
      .ovr_o  (ovr_v[p])
    );
  end

  assign own      = gnt_q[1];
  assign win      = (&pend) ? ~last_q : pend[1];
  assign ovr      = ovr_v;
  assign gnt      = gnt_q;
  assign rd_data0 = rd_data_m;
  assign rd_data1 = rd_data_m;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    clr     = '0;
    wrt_m   = 1'b0;
    done0   = 1'b0;
    done1   = 1'b0;
    sel     = own;
    case (state_q)
      IDLE: if (|pend) begin
        sel     = win;
        wrt_m   = 1'b1;
        gnt_d   = win ? 2'b10 : 2'b01;
        last_d  = win;
        state_d = XFER;
      end
      XFER: if (done_m) begin
        clr[own] = 1'b1;
        done0    = ~own;
        done1    = own;
        // Keep the grant unless the lock cap is hit while the other port waits.
        if (lock_v[own] && (cnt_q < CNT_MAX || !pend[~own])) begin
          state_d = HOLD;
          if (cnt_q < CNT_MAX) cnt_d = cnt_q + 1'b1;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
          gnt_d   = '0;
        end
      end
      HOLD: if (pend[own]) begin
        wrt_m   = 1'b1;
        state_d = XFER;
      end else if (!lock_v[own]) begin
        state_d = IDLE;
        cnt_d   = '0;
        gnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    cmd_m = pcmd[sel];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_spi_mstr_arb.sv
// Bench for spi_mstr_arb: dut0 has LOCK_MAX=16, dut1 has LOCK_MAX=4; the SPI master is modelled by the bench.
module tb_spi_mstr_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       wrt0, wrt1, lock0, lock1, done_m, done0, done1, wrt_m;
  logic [1:0][15:0] cmd0, cmd1, rd_data_m, rd_data0, rd_data1, cmd_m;
  logic [1:0][1:0]  ovr, gnt;
  int total = 0;
  int bad = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    spi_mstr_arb #(.LOCK_MAX(g == 0 ? 16 : 4)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .wrt0(wrt0[g]), .cmd0(cmd0[g]), .lock0(lock0[g]), .done0(done0[g]), .rd_data0(rd_data0[g]),
      .wrt1(wrt1[g]), .cmd1(cmd1[g]), .lock1(lock1[g]), .done1(done1[g]), .rd_data1(rd_data1[g]),
      .ovr(ovr[g]), .gnt(gnt[g]), .wrt_m(wrt_m[g]), .cmd_m(cmd_m[g]),
      .done_m(done_m[g]), .rd_data_m(rd_data_m[g])
    );
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic do_reset();
    wrt0 = '0; wrt1 = '0; lock0 = '0; lock1 = '0; done_m = '0;
    cmd0 = '0; cmd1 = '0; rd_data_m = '0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  // Wait (bounded) for the next wrt_m of dut d and check it belongs to port p with command c.
  task automatic issue_check(input int d, input int p, input logic [15:0] c, output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (wrt_m[d]) begin lat = i; break; end
      @(negedge clk);
    end
    total++;
    if (lat < 0) begin
      bad++;
      $display("FAIL issue_timeout dut%0d: no wrt_m seen, wanted port%0d cmd %h", d, p, c);
    end else begin
      total++;
      if (cmd_m[d] !== c) begin
        bad++;
        $display("FAIL issue_cmd dut%0d: cmd_m got %h want %h (port%0d)", d, cmd_m[d], c, p);
      end
      @(negedge clk); #1;
      total++;
      if (gnt[d] !== ((p == 1) ? 2'b10 : 2'b01)) begin
        bad++;
        $display("FAIL issue_gnt dut%0d: gnt got %b want port%0d", d, gnt[d], p);
      end
    end
  endtask

  // Model SPI_mstr16 finishing after a random delay; optional client wrt pulses ride on the done cycle.
  task automatic complete(input int d, input int p, input logic [15:0] rd,
                          input logic cw0, input logic [15:0] cc0,
                          input logic cw1, input logic [15:0] cc1);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk);
    done_m[d] = 1'b1; rd_data_m[d] = rd;
    wrt0[d] = cw0; cmd0[d] = cc0; wrt1[d] = cw1; cmd1[d] = cc1;
    #1;
    total++;
    if (done0[d] !== (p == 0) || done1[d] !== (p == 1)) begin
      bad++;
      $display("FAIL done_pulse dut%0d: done0/1 got %b%b want owner port%0d", d, done0[d], done1[d], p);
    end
    total++;
    if (rd_data0[d] !== rd || rd_data1[d] !== rd) begin
      bad++;
      $display("FAIL rd_data dut%0d: got %h/%h want %h", d, rd_data0[d], rd_data1[d], rd);
    end
    @(negedge clk);
    done_m[d] = 1'b0; wrt0[d] = 1'b0; wrt1[d] = 1'b0;
  endtask

  task automatic test_reset();
    wrt0 = '0; wrt1 = '0; lock0 = '0; lock1 = '0; cmd0 = '0; cmd1 = '0; rd_data_m = '0;
    @(negedge clk); rst_n = 1'b0; done_m = '1;
    #1;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (gnt[d] !== 2'b00 || ovr[d] !== 2'b00 || wrt_m[d] !== 1'b0) begin
        bad++;
        $display("FAIL reset_state dut%0d: gnt %b ovr %b wrt_m %b want 0", d, gnt[d], ovr[d], wrt_m[d]);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (done0[d] !== 1'b0 || done1[d] !== 1'b0 || gnt[d] !== 2'b00) begin
        bad++;
        $display("FAIL idle_done_ignored dut%0d: done %b%b gnt %b want 0", d, done0[d], done1[d], gnt[d]);
      end
    end
    @(negedge clk); done_m = '0;
  endtask

  task automatic test_single();
    int lat;
    do_reset();
    @(negedge clk); wrt0[0] = 1'b1; cmd0[0] = 16'hA200;
    @(negedge clk); wrt0[0] = 1'b0;
    issue_check(0, 0, 16'hA200, lat);
    total++;
    if (lat !== 0) begin
      bad++;
      $display("FAIL single_latency: wrt_m after %0d extra cycles want 0", lat);
    end
    complete(0, 0, 16'h00C3, 1'b0, 16'h0, 1'b0, 16'h0);
    #1;
    total++;
    if (gnt[0] !== 2'b00 || wrt_m[0] !== 1'b0) begin
      bad++;
      $display("FAIL single_idle: gnt %b wrt_m %b want 00/0", gnt[0], wrt_m[0]);
    end
  endtask

  task automatic test_tie();
    int lat;
    logic [15:0] c0, c1, c2;
    c0 = 16'($urandom); c1 = 16'($urandom); c2 = 16'($urandom);
    do_reset();
    @(negedge clk); wrt0[0] = 1'b1; cmd0[0] = c0; wrt1[0] = 1'b1; cmd1[0] = c1;
    @(negedge clk); wrt0[0] = 1'b0; wrt1[0] = 1'b0;
    // first tie after reset goes to port0; port0 re-requests on its done, the new tie goes to port1
    issue_check(0, 0, c0, lat);
    complete(0, 0, 16'($urandom), 1'b1, c2, 1'b0, 16'h0);
    issue_check(0, 1, c1, lat);
    complete(0, 1, 16'($urandom), 1'b0, 16'h0, 1'b0, 16'h0);
    issue_check(0, 0, c2, lat);
    complete(0, 0, 16'($urandom), 1'b0, 16'h0, 1'b0, 16'h0);
  endtask

  task automatic test_lock_burst();
    int lat;
    logic [15:0] c [11];
    logic [15:0] c1;
    for (int i = 0; i < 11; i++) c[i] = 16'($urandom);
    c1 = 16'($urandom);
    do_reset();
    lock0[0] = 1'b1;
    @(negedge clk); wrt0[0] = 1'b1; cmd0[0] = c[0];
    @(negedge clk); wrt0[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      issue_check(0, 0, c[i], lat);
      complete(0, 0, 16'($urandom), (i < 9), c[i+1], (i == 0), c1);
    end
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (wrt_m[0] !== 1'b0 || gnt[0] !== 2'b01) begin
        bad++;
        $display("FAIL hold_reserved: wrt_m %b gnt %b want 0/01", wrt_m[0], gnt[0]);
      end
      @(negedge clk);
    end
    lock0[0] = 1'b0;
    issue_check(0, 1, c1, lat);
    complete(0, 1, 16'($urandom), 1'b0, 16'h0, 1'b0, 16'h0);
  endtask

  // dut1: LOCK_MAX=4, so port0 gets exactly 4 transactions before waiting port1 is served
  task automatic test_starve();
    int lat;
    logic [15:0] c [6];
    logic [15:0] c1;
    for (int i = 0; i < 6; i++) c[i] = 16'($urandom);
    c1 = 16'($urandom);
    do_reset();
    lock0[1] = 1'b1;
    @(negedge clk); wrt0[1] = 1'b1; cmd0[1] = c[0];
    @(negedge clk); wrt0[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue_check(1, 0, c[i], lat);
      complete(1, 0, 16'($urandom), 1'b1, c[i+1], (i == 0), c1);
    end
    issue_check(1, 1, c1, lat);
    complete(1, 1, 16'($urandom), 1'b0, 16'h0, 1'b0, 16'h0);
    issue_check(1, 0, c[4], lat);
    lock0[1] = 1'b0;
    complete(1, 0, 16'($urandom), 1'b0, 16'h0, 1'b0, 16'h0);
    #1;
    total++;
    if (gnt[1] !== 2'b00) begin
      bad++;
      $display("FAIL starve_release: gnt %b want 00", gnt[1]);
    end
  endtask

  task automatic test_overrun();
    logic [15:0] ca, cb, cc;
    ca = 16'($urandom); cb = ~ca; cc = ca ^ 16'h5A5A;
    do_reset();
    @(negedge clk); wrt1[0] = 1'b1; cmd1[0] = ca;
    @(negedge clk); cmd1[0] = cb;
    #1;
    total++;
    if (wrt_m[0] !== 1'b1 || cmd_m[0] !== ca) begin
      bad++;
      $display("FAIL ovr_first_issue: wrt_m %b cmd_m %h want 1/%h", wrt_m[0], cmd_m[0], ca);
    end
    @(negedge clk); cmd1[0] = cc;
    #1;
    total++;
    if (ovr[0] !== 2'b10) begin
      bad++;
      $display("FAIL ovr_flag: ovr %b want 10", ovr[0]);
    end
    @(negedge clk); wrt1[0] = 1'b0;
    #1;
    total++;
    if (cmd_m[0] !== ca) begin
      bad++;
      $display("FAIL ovr_kept_cmd: cmd_m %h want %h", cmd_m[0], ca);
    end
    complete(0, 1, 16'($urandom), 1'b0, 16'h0, 1'b0, 16'h0);
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (wrt_m[0] !== 1'b0 || ovr[0] !== 2'b10) begin
        bad++;
        $display("FAIL ovr_discarded: wrt_m %b ovr %b want 0/10", wrt_m[0], ovr[0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [15:0] c1, c0;
    c1 = 16'($urandom); c0 = 16'($urandom);
    do_reset();
    @(negedge clk); wrt1[0] = 1'b1; cmd1[0] = c1;
    @(negedge clk); wrt1[0] = 1'b0;
    issue_check(0, 1, c1, lat);
    @(negedge clk); rst_n = 1'b0;
    #1;
    total++;
    if (gnt[0] !== 2'b00 || wrt_m[0] !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_gnt: gnt %b wrt_m %b want 00/0", gnt[0], wrt_m[0]);
    end
    @(negedge clk); rst_n = 1'b1; done_m[0] = 1'b1; rd_data_m[0] = 16'($urandom);
    #1;
    total++;
    if (done1[0] !== 1'b0 || done0[0] !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_done: done0/1 %b%b want 00", done0[0], done1[0]);
    end
    @(negedge clk); done_m[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (wrt_m[0] !== 1'b0) begin
        bad++;
        $display("FAIL rst_mid_pend: wrt_m %b want 0", wrt_m[0]);
      end
      @(negedge clk);
    end
    @(negedge clk); wrt0[0] = 1'b1; cmd0[0] = c0;
    @(negedge clk); wrt0[0] = 1'b0;
    issue_check(0, 0, c0, lat);
    complete(0, 0, 16'($urandom), 1'b0, 16'h0, 1'b0, 16'h0);
  endtask

  // Reference: on a tie the port not served most recently wins; last served starts as port1 after reset.
  task automatic test_random();
    int lat, pick;
    bit mlast;
    logic [1:0] pm;
    logic [15:0] pc [2];
    do_reset();
    mlast = 1'b1;
    for (int r = 0; r < 16; r++) begin
      pm = 2'($urandom_range(1, 3));
      pc[0] = 16'($urandom); pc[1] = 16'($urandom);
      @(negedge clk);
      wrt0[0] = pm[0]; cmd0[0] = pc[0]; wrt1[0] = pm[1]; cmd1[0] = pc[1];
      @(negedge clk); wrt0[0] = 1'b0; wrt1[0] = 1'b0;
      while (pm != 2'b00) begin
        pick = (pm == 2'b11) ? int'(!mlast) : int'(pm[1]);
        issue_check(0, pick, pc[pick], lat);
        complete(0, pick, 16'($urandom), 1'b0, 16'h0, 1'b0, 16'h0);
        mlast = pick[0];
        pm[pick] = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_lock_burst();
    test_starve();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
